dma_priority_arbiter: RTL and testbench

// Priority/hold-request sequencer for the 8237-style DMA controller.
// - Picks one DMA channel from hardware DREQs and software requests.
// - Raises HRQ to the CPU and waits for HLDA.
// - Drives the winning DACK, framed by the assertDACK/deassertDACK strobes from

---
 rtl/dma_priority_arbiter.sv | 156 +++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// DMA channel picker and HRQ/HLDA/DACK sequencer: hrq rises 1 cycle after a request wins.
// There is no backpressure: the CPU's HLDA and the timing strobes pace the sequence, and a lost HLDA aborts it.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              hlda,
  input  logic              assertDACK,
  input  logic              deassertDACK,
  input  logic              cmdDisable,
  input  logic              cmdRotating,
  input  logic              cmdDreqActiveLow,
  input  logic              cmdDackActiveHigh,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] swReq,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic [CH_W-1:0]   activeChannel,
  output logic              channelActive,
  output logic [NUM_CH-1:0] swReqAck
);

  typedef enum logic [1:0] {IDLE, HOLD_REQ, ACK_WAIT, SERVICE} state_t;

  state_t            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_int_q, dack_int_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic              chan_active_q, chan_active_d;
  logic [NUM_CH-1:0] sw_ack_q, sw_ack_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic              is_sw_q, is_sw_d;

  logic [NUM_CH-1:0] req_eff;
  logic [CH_W-1:0]   base;
  logic [CH_W:0]     sum;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   winner;
  logic              found;

  assign req_eff = ((dreq ^ {NUM_CH{cmdDreqActiveLow}}) & ~maskReg) | swReq;

  // Scan channels starting at the highest-priority one, wrapping modulo NUM_CH.
  always_comb begin
    base   = '0;
    sum    = '0;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    if (cmdRotating) begin
      base = (last_q == CH_W'(NUM_CH - 1)) ? '0 : last_q + CH_W'(1);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, base} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      idx = sum[CH_W-1:0];
      if (!found && req_eff[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hrq_d         = hrq_q;
    dack_int_d    = dack_int_q;
    active_ch_d   = active_ch_q;
    chan_active_d = chan_active_q;
    sw_ack_d      = '0;
    last_d        = last_q;
    is_sw_d       = is_sw_q;
    case (state_q)
      IDLE: begin
        if (!cmdDisable && found) begin
          active_ch_d = winner;
          is_sw_d     = swReq[winner];
          hrq_d       = 1'b1;
          state_d     = HOLD_REQ;
        end
      end
      HOLD_REQ: begin
        if (hlda) begin
          state_d = ACK_WAIT;
        end else if (!req_eff[active_ch_q]) begin
          hrq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      ACK_WAIT: begin
        if (!hlda) begin
          hrq_d         = 1'b0;
          dack_int_d    = '0;
          chan_active_d = 1'b0;
          state_d       = IDLE;
        end else if (assertDACK) begin
          dack_int_d              = '0;
          dack_int_d[active_ch_q] = 1'b1;
          chan_active_d           = 1'b1;
          state_d                 = SERVICE;
        end
      end
      SERVICE: begin
        // Losing HLDA is an abort: no rotation update and no software ack.
        if (!hlda) begin
          hrq_d         = 1'b0;
          dack_int_d    = '0;
          chan_active_d = 1'b0;
          state_d       = IDLE;
        end else if (deassertDACK) begin
          hrq_d                 = 1'b0;
          dack_int_d            = '0;
          chan_active_d         = 1'b0;
          last_d                = active_ch_q;
          sw_ack_d[active_ch_q] = is_sw_q;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      hrq_q         <= 1'b0;
      dack_int_q    <= '0;
      active_ch_q   <= '0;
      chan_active_q <= 1'b0;
      sw_ack_q      <= '0;
      last_q        <= CH_W'(NUM_CH - 1);
      is_sw_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hrq_q         <= hrq_d;
      dack_int_q    <= dack_int_d;
      active_ch_q   <= active_ch_d;
      chan_active_q <= chan_active_d;
      sw_ack_q      <= sw_ack_d;
      last_q        <= last_d;
      is_sw_q       <= is_sw_d;
    end
  end

  assign hrq           = hrq_q;
  assign dack          = cmdDackActiveHigh ? dack_int_q : ~dack_int_q;
  assign activeChannel = active_ch_q;
  assign channelActive = chan_active_q;
  assign swReqAck      = sw_ack_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: vector table, directed corner sequences, then random traffic vs a model.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] dreq;
  logic       hlda;
  logic       assertDACK;
  logic       deassertDACK;
  logic       cmdDisable;
  logic       cmdRotating;
  logic       cmdDreqActiveLow;
  logic       cmdDackActiveHigh;
  logic [3:0] maskReg;
  logic [3:0] swReq;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] activeChannel;
  logic       channelActive;
  logic [3:0] swReqAck;

  int n_cmp;
  int n_fail;

  dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .dreq(dreq), .hlda(hlda),
    .assertDACK(assertDACK), .deassertDACK(deassertDACK),
    .cmdDisable(cmdDisable), .cmdRotating(cmdRotating),
    .cmdDreqActiveLow(cmdDreqActiveLow), .cmdDackActiveHigh(cmdDackActiveHigh),
    .maskReg(maskReg), .swReq(swReq), .hrq(hrq), .dack(dack),
    .activeChannel(activeChannel), .channelActive(channelActive), .swReqAck(swReqAck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_dack(input int ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    return cmdDackActiveHigh ? oh : ~oh;
  endfunction

  task automatic idle_inputs();
    dreq = 4'b0000; hlda = 1'b0; assertDACK = 1'b0; deassertDACK = 1'b0;
    cmdDisable = 1'b0; cmdRotating = 1'b0; cmdDreqActiveLow = 1'b0;
    cmdDackActiveHigh = 1'b0; maskReg = 4'b0000; swReq = 4'b0000;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Runs one full grant/ack/service cycle for the channel the DUT should pick.
  task automatic serve(input string tag, input int exp_ch, input logic [3:0] exp_swack);
    int n;
    n = 0;
    hlda = 1'b0; assertDACK = 1'b0; deassertDACK = 1'b0;
    while (hrq !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    check({tag, "_hrq"}, 32'(hrq), 32'd1);
    check({tag, "_ch"}, 32'(activeChannel), 32'(exp_ch));
    hlda = 1'b1;
    tick();
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    check({tag, "_dack"}, 32'({channelActive, dack}), 32'({1'b1, exp_dack(exp_ch)}));
    tick();
    deassertDACK = 1'b1;
    tick();
    deassertDACK = 1'b0;
    hlda = 1'b0;
    check({tag, "_end"}, 32'({hrq, channelActive, dack, swReqAck}),
          32'({1'b0, 1'b0, exp_dack(-1 + 5) | (cmdDackActiveHigh ? 4'b0000 : 4'b1111), exp_swack}));
  endtask

  // Behavioural reference: stage 0 idle, 1 requesting hold, 2 waiting for ack strobe, 3 servicing.
  int         m_stage;
  logic       m_hrq;
  logic [3:0] m_dackv;
  logic [1:0] m_ch;
  logic       m_ca;
  logic [3:0] m_swack;
  int         m_last;
  logic       m_issw;

  function automatic int pick(input logic [3:0] req, input logic rot, input int last);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = rot ? (last + 1 + k) % 4 : k;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_abort();
    m_stage = 0; m_hrq = 1'b0; m_dackv = 4'b0000; m_ca = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] req;
    int p;
    req = ((dreq ^ {4{cmdDreqActiveLow}}) & ~maskReg) | swReq;
    m_swack = 4'b0000;
    if (RESET) begin
      model_abort();
      m_ch = 2'd0; m_last = 3; m_issw = 1'b0;
    end else if (m_stage == 0) begin
      p = cmdDisable ? -1 : pick(req, cmdRotating, m_last);
      if (p >= 0) begin
        m_ch = 2'(p); m_issw = swReq[p]; m_hrq = 1'b1; m_stage = 1;
      end
    end else if (m_stage == 1) begin
      if (hlda) m_stage = 2;
      else if (!req[m_ch]) begin m_stage = 0; m_hrq = 1'b0; end
    end else if (m_stage == 2) begin
      if (!hlda) model_abort();
      else if (assertDACK) begin m_dackv = 4'b0001 << m_ch; m_ca = 1'b1; m_stage = 3; end
    end else begin
      if (!hlda) model_abort();
      else if (deassertDACK) begin
        m_swack[m_ch] = m_issw;
        m_last = int'(m_ch);
        model_abort();
      end
    end
  endtask

  typedef struct {
    logic [3:0] dreq;
    logic       hlda;
    logic       a;
    logic       d;
    logic       e_hrq;
    logic [3:0] e_dack;
    logic [1:0] e_ch;
    logic       e_ca;
  } vec_t;

  vec_t tbl[13];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    // Fixed priority, active-high dreq, active-low dack: ch1 then ch2.
    tbl[0]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[1]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[2]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[3]  = '{4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[4]  = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    tbl[5]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    tbl[6]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b0};
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 2'd2, 1'b0};
    tbl[9]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 2'd2, 1'b0};
    tbl[10] = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 2'd2, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 2'd2, 1'b0};

    idle_inputs();
    do_reset();
    check("reset_state", 32'({hrq, dack, activeChannel, channelActive, swReqAck}),
          32'({1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000}));

    for (int i = 0; i < 13; i++) begin
      dreq = tbl[i].dreq; hlda = tbl[i].hlda;
      assertDACK = tbl[i].a; deassertDACK = tbl[i].d;
      tick();
      check($sformatf("vec[%0d]", i), 32'({hrq, dack, activeChannel, channelActive}),
            32'({tbl[i].e_hrq, tbl[i].e_dack, tbl[i].e_ch, tbl[i].e_ca}));
    end
    idle_inputs();

    // Rotating order from reset starts at ch0.
    do_reset();
    cmdRotating = 1'b1; dreq = 4'b1111;
    serve("rot0", 0, 4'b0000);
    serve("rot1", 1, 4'b0000);
    serve("rot2", 2, 4'b0000);
    serve("rot3", 3, 4'b0000);
    serve("rot4", 0, 4'b0000);
    idle_inputs();

    // Masked hardware requests, then an unmasked software request.
    do_reset();
    maskReg = 4'b1111; dreq = 4'b1111;
    tick(); tick(); tick();
    check("mask_hrq", 32'(hrq), 32'd0);
    swReq = 4'b1000;
    serve("sw", 3, 4'b1000);
    swReq = 4'b0000;
    tick();
    check("sw_ack_pulse", 32'({swReqAck, hrq}), 32'({4'b0000, 1'b0}));
    idle_inputs();

    // Request withdrawn while waiting for HLDA.
    do_reset();
    dreq = 4'b0100;
    tick();
    check("wd_hrq_up", 32'({hrq, activeChannel}), 32'({1'b1, 2'd2}));
    dreq = 4'b0000;
    tick();
    check("wd_hrq_down", 32'(hrq), 32'd0);

    // HLDA lost during service.
    dreq = 4'b0110;
    tick();
    hlda = 1'b1; tick();
    assertDACK = 1'b1; tick(); assertDACK = 1'b0;
    check("abort_svc", 32'({dack, channelActive}), 32'({4'b1101, 1'b1}));
    hlda = 1'b0; tick();
    check("abort_out", 32'({hrq, dack, channelActive, swReqAck}), 32'({1'b0, 4'b1111, 1'b0, 4'b0000}));
    tick();
    check("abort_next", 32'({hrq, activeChannel}), 32'({1'b1, 2'd1}));
    idle_inputs();

    // Inverted pin polarities.
    do_reset();
    cmdDreqActiveLow = 1'b1; cmdDackActiveHigh = 1'b1; dreq = 4'b1110;
    serve("pol", 0, 4'b0000);
    idle_inputs();

    // Both strobes together: assert wins in ACK_WAIT, deassert wins in SERVICE.
    do_reset();
    dreq = 4'b0001;
    tick();
    hlda = 1'b1; tick();
    assertDACK = 1'b1; deassertDACK = 1'b1; tick();
    check("both_ackwait", 32'({channelActive, dack}), 32'({1'b1, 4'b1110}));
    tick();
    check("both_service", 32'({channelActive, hrq, dack}), 32'({1'b0, 1'b0, 4'b1111}));
    idle_inputs();

    // Reset in the middle of a service.
    do_reset();
    dreq = 4'b0100;
    tick();
    hlda = 1'b1; tick();
    assertDACK = 1'b1; tick(); assertDACK = 1'b0;
    check("rst_svc", 32'(channelActive), 32'd1);
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("rst_mid", 32'({hrq, dack, channelActive, activeChannel}), 32'({1'b0, 4'b1111, 1'b0, 2'd0}));
    idle_inputs();

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      RESET = (c == 0) || ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 40) == 0) cmdRotating = 1'($urandom);
      if ($urandom_range(0, 60) == 0) cmdDreqActiveLow = 1'($urandom);
      if ($urandom_range(0, 60) == 0) cmdDackActiveHigh = 1'($urandom);
      if ($urandom_range(0, 30) == 0) cmdDisable = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) dreq = 4'($urandom);
      if ($urandom_range(0, 20) == 0) maskReg = 4'($urandom) & 4'($urandom);
      swReq = ($urandom_range(0, 7) == 0) ? 4'($urandom) & 4'($urandom) : 4'b0000;
      hlda = m_hrq ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
      assertDACK = ($urandom_range(0, 3) == 0);
      deassertDACK = ($urandom_range(0, 3) == 0);
      model_step();
      tick();
      check($sformatf("rand[%0d]", c),
            32'({hrq, dack, activeChannel, channelActive, swReqAck}),
            32'({m_hrq, (cmdDackActiveHigh ? m_dackv : ~m_dackv), m_ch, m_ca, m_swack}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
